// File: rtl/ppu_wb_packer.sv
// ppu_wb_packer: output-side sequencer for the PPU. It accepts psums, drives the
// maxpool/relu controls, packs 8-bit results little-endian into 32-bit words and
// hands them to the GLB as writeback requests with byte strobes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | waiting for cfg_start; configuration latched on the start pulse
//   S_RUN   | accepting psums, capturing PPU bytes, issuing packed words
//   S_DRAIN | all bytes captured; waiting for the last word to be accepted
//   S_DONE  | one-cycle done pulse, then back to S_IDLE
module ppu_wb_packer #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [2:0]        cfg_pool_size,
  input  logic [CNT_W-1:0]  cfg_out_count,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic              ppu_maxpool_en,
  output logic              ppu_maxpool_init,
  output logic              ppu_relu_sel,
  input  logic [7:0]        ppu_data_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic [3:0]        wb_strb,
  output logic              busy,
  output logic              done
);

  // Psum budget is out_count * K, so it needs three extra bits over the byte count.
  localparam int PW = CNT_W + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        k_cfg;
  logic [2:0]        k_r;
  logic              relu_r;
  logic              pool_mode;
  logic              start;
  logic              accept;
  logic              cap;
  logic              last_byte;
  logic              flush;
  logic              wb_fire;
  logic              win_last;

  logic [PW-1:0]     psum_left;
  logic [CNT_W-1:0]  bytes_left;
  logic [2:0]        win_cnt;
  logic              cap_pend;
  logic [1:0]        lane;

  logic [31:0]       pack_data;
  logic [3:0]        pack_strb;
  logic [31:0]       merge_data;
  logic [3:0]        merge_strb;

  logic              hold_valid;
  logic [31:0]       hold_data;
  logic [3:0]        hold_strb;
  logic [ADDR_W-1:0] addr_r;

  assign k_cfg     = (cfg_pool_size == 3'd0) ? 3'd1 : cfg_pool_size;
  assign pool_mode = (k_r > 3'd1);
  assign start     = (state == S_IDLE) && cfg_start;
  assign accept    = psum_valid && psum_ready;
  assign win_last  = (win_cnt == (k_r - 3'd1));

  // With pooling the PPU comparator is registered, so the window result is
  // valid one cycle after its last psum; without pooling the path is combinational.
  assign cap       = pool_mode ? cap_pend : accept;
  assign last_byte = (bytes_left == CNT_W'(1));
  assign flush     = cap && ((lane == 2'd3) || last_byte);
  assign wb_fire   = hold_valid && wb_ready;

  assign merge_data = pack_data | ({24'd0, ppu_data_out} << {lane, 3'b000});
  assign merge_strb = pack_strb | (4'b0001 << lane);

  assign ppu_maxpool_en   = pool_mode && accept;
  assign ppu_maxpool_init = ppu_maxpool_en && (win_cnt == 3'd0);
  assign ppu_relu_sel     = relu_r;

  assign wb_valid = hold_valid;
  assign wb_addr  = addr_r;
  assign wb_data  = hold_data;
  assign wb_strb  = hold_strb;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the state-derived handshake and status outputs.
  always_comb begin
    state_nxt  = state;
    psum_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_nxt = (cfg_out_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy       = 1'b1;
        // Holding off while the hold word is full guarantees a capture never
        // has to flush into an occupied hold register.
        psum_ready = !hold_valid && (psum_left != '0);
        if (cap && last_byte) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (wb_fire) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Pass configuration, latched on start and held until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r    <= 3'd0;
      relu_r <= 1'b0;
    end else if (start) begin
      k_r    <= k_cfg;
      relu_r <= (k_cfg > 3'd1);
    end
  end

  // Psum-side bookkeeping: remaining psum budget, window position, pending capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_left <= '0;
      win_cnt   <= 3'd0;
      cap_pend  <= 1'b0;
    end else if (start) begin
      psum_left <= PW'(cfg_out_count) * PW'(k_cfg);
      win_cnt   <= 3'd0;
      cap_pend  <= 1'b0;
    end else begin
      cap_pend <= pool_mode && accept && win_last;
      if (accept) begin
        psum_left <= psum_left - PW'(1);
        win_cnt   <= win_last ? 3'd0 : (win_cnt + 3'd1);
      end
    end
  end

  // Byte-side bookkeeping: bytes still to capture and the next lane to fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_left <= '0;
      lane       <= 2'd0;
    end else if (start) begin
      bytes_left <= cfg_out_count;
      lane       <= 2'd0;
    end else if (cap) begin
      bytes_left <= bytes_left - CNT_W'(1);
      lane       <= lane + 2'd1;
    end
  end

  // Pack register: accumulate captured bytes, empty it when the word moves to hold.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      pack_data <= 32'd0;
      pack_strb <= 4'd0;
    end else if (cap) begin
      if (flush) begin
        pack_data <= 32'd0;
        pack_strb <= 4'd0;
      end else begin
        pack_data <= merge_data;
        pack_strb <= merge_strb;
      end
    end
  end

  // Hold register: one word waiting for the GLB; cleared when it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
      hold_strb  <= 4'd0;
    end else if (flush) begin
      hold_valid <= 1'b1;
      hold_data  <= merge_data;
      hold_strb  <= merge_strb;
    end else if (wb_fire) begin
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
      hold_strb  <= 4'd0;
    end
  end

  // Writeback address: base on start, advance one word per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= '0;
    end else if (start) begin
      addr_r <= cfg_base_addr;
    end else if (wb_fire) begin
      addr_r <= addr_r + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_ppu_wb_packer.sv
// Bench for ppu_wb_packer: a PPU environment model plus a word-level reference
// model of the pass (expected writeback words computed from the psum stream).
module tb_ppu_wb_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [2:0]  cfg_pool_size;
  logic [15:0] cfg_out_count;
  logic [15:0] cfg_base_addr;
  logic        psum_valid;
  logic        psum_ready;
  logic        ppu_maxpool_en;
  logic        ppu_maxpool_init;
  logic        ppu_relu_sel;
  logic [7:0]  ppu_data_out;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_strb;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ppu_wb_packer #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_pool_size(cfg_pool_size),
    .cfg_out_count(cfg_out_count), .cfg_base_addr(cfg_base_addr),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .ppu_maxpool_en(ppu_maxpool_en), .ppu_maxpool_init(ppu_maxpool_init),
    .ppu_relu_sel(ppu_relu_sel), .ppu_data_out(ppu_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_strb(wb_strb), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // psum stream of the current pass, as the byte each psum becomes in the PPU
  logic [7:0]  psums [0:255];

  // reference model
  bit          m_active, m_done_due, m_relu;
  int          m_k, m_idx, m_total;
  logic [7:0]  m_max;
  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];

  // stimulus knobs
  int pv_pct, wr_pct, stall_left;
  bit stall_after_first, first_hs_seen;

  // per-pass observation log
  int          log_n, en_count, init_count, done_count, start_cyc, done_cyc;
  logic [15:0] log_addr [0:15];
  logic [31:0] log_data [0:15];
  logic [3:0]  log_strb [0:15];
  int          init_pos [0:15];

  // wb stability tracking
  bit          prev_stall;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output byte j of the pass: the maximum of its K psums.
  function automatic logic [7:0] byte_at(input int j, input int k);
    logic [7:0] m;
    m = psums[j * k];
    for (int i = 1; i < k; i++) if (psums[j * k + i] > m) m = psums[j * k + i];
    return m;
  endfunction

  function automatic void model_reset();
    m_active = 1'b0; m_done_due = 1'b0; m_relu = 1'b0;
    m_k = 1; m_idx = 0; m_total = 0; m_max = 8'd0;
    q_addr.delete(); q_data.delete(); q_strb.delete();
    prev_stall = 1'b0; stall_left = 0;
  endfunction

  function automatic void model_start();
    int cnt;
    logic [31:0] d;
    logic [3:0]  s;
    cnt     = int'(cfg_out_count);
    m_k     = (cfg_pool_size == 3'd0) ? 1 : int'(cfg_pool_size);
    m_relu  = (m_k > 1);
    m_total = cnt * m_k;
    m_idx   = 0;
    q_addr.delete(); q_data.delete(); q_strb.delete();
    for (int w = 0; w * 4 < cnt; w++) begin
      d = 32'd0; s = 4'd0;
      for (int l = 0; l < 4 && (w * 4 + l) < cnt; l++) begin
        d = d | (32'(byte_at(w * 4 + l, m_k)) << (8 * l));
        s[l] = 1'b1;
      end
      q_addr.push_back(16'(int'(cfg_base_addr) + 4 * w));
      q_data.push_back(d);
      q_strb.push_back(s);
    end
  endfunction

  // One clock: check at the falling edge, then advance the models and drive
  // new inputs just after the rising edge.
  task automatic step();
    logic s_acc, s_hs, s_en, s_init, en_exp, start_ok, done_next;
    logic [15:0] ea;
    logic [31:0] ed;
    logic [3:0]  es;
    @(negedge clk);
    cyc++;
    s_acc  = psum_valid && psum_ready;
    s_hs   = wb_valid && wb_ready;
    s_en   = ppu_maxpool_en;
    s_init = ppu_maxpool_init;
    if (chk_en) begin
      en_exp = (m_k > 1) && s_acc;
      chk("busy", 32'(busy), 32'(m_active));
      chk("psum_ready", 32'(psum_ready), 32'(m_active && !wb_valid && (m_idx < m_total)));
      chk("done", 32'(done), 32'(m_done_due));
      chk("relu_sel", 32'(ppu_relu_sel), 32'(m_relu));
      chk("maxpool_en", 32'(s_en), 32'(en_exp));
      chk("maxpool_init", 32'(s_init), 32'(en_exp && (m_idx % m_k == 0)));
      if (wb_valid) chk("inv_no_ready_while_hold", 32'(psum_ready), 32'(0));
      if (!m_active) chk("wb_valid_outside_pass", 32'(wb_valid), 32'(0));
      if (!wb_valid) begin
        chk("wb_data_idle", wb_data, 32'd0);
        chk("wb_strb_idle", 32'(wb_strb), 32'd0);
      end
      if (prev_stall) begin
        chk("wb_valid_stable", 32'(wb_valid), 32'd1);
        chk("wb_addr_stable", 32'(wb_addr), 32'(prev_addr));
        chk("wb_data_stable", wb_data, prev_data);
        chk("wb_strb_stable", 32'(wb_strb), 32'(prev_strb));
      end
      if (s_hs) begin
        chk("wb_word_expected", 32'(q_addr.size() > 0), 32'd1);
        if (q_addr.size() > 0) begin
          ea = q_addr.pop_front(); ed = q_data.pop_front(); es = q_strb.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(ea));
          chk("wb_data", wb_data, ed);
          chk("wb_strb", 32'(wb_strb), 32'(es));
        end
        if (log_n < 16) begin
          log_addr[log_n] = wb_addr; log_data[log_n] = wb_data; log_strb[log_n] = wb_strb;
        end
        log_n++;
      end
    end
    if (s_en) en_count++;
    if (s_init) begin
      if (init_count < 16) init_pos[init_count] = m_idx;
      init_count++;
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    prev_stall = wb_valid && !wb_ready;
    prev_addr = wb_addr; prev_data = wb_data; prev_strb = wb_strb;

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      start_ok  = cfg_start && !m_active && !m_done_due;
      done_next = 1'b0;
      if (s_acc) begin
        if (m_k > 1) begin
          if (s_init) m_max = psums[m_idx];
          else if (psums[m_idx] > m_max) m_max = psums[m_idx];
        end
        m_idx++;
      end
      if (s_hs && m_active && q_addr.size() == 0) begin
        m_active  = 1'b0;
        done_next = 1'b1;
      end
      if (start_ok) begin
        model_start();
        if (m_total == 0) done_next = 1'b1;
        else m_active = 1'b1;
      end
      m_done_due = done_next;
      if (s_hs && stall_after_first && !first_hs_seen) begin
        first_hs_seen = 1'b1;
        stall_left = 5;
      end
    end
    psum_valid = ($urandom_range(0, 99) < pv_pct);
    if (stall_left > 0) begin
      wb_ready = 1'b0;
      stall_left--;
    end else begin
      wb_ready = ($urandom_range(0, 99) < wr_pct);
    end
    ppu_data_out = (m_k == 1) ? psums[m_idx] : m_max;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_psum_ready"}, 32'(psum_ready), 32'd0);
    chk({tag, "_maxpool_en"}, 32'(ppu_maxpool_en), 32'd0);
    chk({tag, "_maxpool_init"}, 32'(ppu_maxpool_init), 32'd0);
    chk({tag, "_relu_sel"}, 32'(ppu_relu_sel), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_strb"}, 32'(wb_strb), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic begin_pass(input int k, input int count, input int base,
                            input int pv, input int wr, input bit fill_rand);
    int keff;
    keff = (k == 0) ? 1 : k;
    log_n = 0; en_count = 0; init_count = 0; done_count = 0;
    first_hs_seen = 1'b0;
    if (fill_rand) for (int i = 0; i < count * keff; i++) psums[i] = 8'($urandom_range(0, 255));
    pv_pct = pv; wr_pct = wr;
    cfg_pool_size = 3'(k); cfg_out_count = 16'(count); cfg_base_addr = 16'(base);
    cfg_start = 1'b1;
    step();
    start_cyc = cyc;
    cfg_start = 1'b0;
  endtask

  task automatic run_pass(input int k, input int count, input int base, input int pv,
                          input int wr, input bit fill_rand, input int inject_at);
    int n;
    begin_pass(k, count, base, pv, wr, fill_rand);
    n = 0;
    while (done_count == 0 && n < 5000) begin
      if (n == inject_at) begin
        cfg_pool_size = 3'd1; cfg_out_count = 16'd0; cfg_base_addr = 16'h0FF0;
        cfg_start = 1'b1;
      end
      step();
      cfg_start = 1'b0;
      n++;
    end
    chk("pass_done_seen", 32'(done_count > 0), 32'd1);
    chk("words_left", 32'(q_addr.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; cfg_start = 1'b0; cfg_pool_size = 3'd0; cfg_out_count = 16'd0;
    cfg_base_addr = 16'd0; psum_valid = 1'b0; wb_ready = 1'b0; ppu_data_out = 8'd0;
    pv_pct = 0; wr_pct = 100; stall_after_first = 1'b0; first_hs_seen = 1'b0;
    log_n = 0; en_count = 0; init_count = 0; done_count = 0; start_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 256; i++) psums[i] = 8'd0;
    model_reset();
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // K=1, 8 bytes 0x01..0x08
    for (int i = 0; i < 8; i++) psums[i] = 8'(i + 1);
    run_pass(1, 8, 16'h0100, 100, 100, 1'b0, -1);
    chk("t1_words", 32'(log_n), 32'd2);
    chk("t1_addr0", 32'(log_addr[0]), 32'h0100);
    chk("t1_data0", log_data[0], 32'h04030201);
    chk("t1_strb0", 32'(log_strb[0]), 32'hF);
    chk("t1_addr1", 32'(log_addr[1]), 32'h0104);
    chk("t1_data1", log_data[1], 32'h08070605);
    chk("t1_strb1", 32'(log_strb[1]), 32'hF);
    chk("t1_maxpool_en_count", 32'(en_count), 32'd0);

    // K=4, window maxima 0x10,0x7F,0x00,0x33
    psums[0] = 8'h05; psums[1] = 8'h10; psums[2] = 8'h02; psums[3] = 8'h0F;
    psums[4] = 8'h7F; psums[5] = 8'h00; psums[6] = 8'h12; psums[7] = 8'h7E;
    psums[8] = 8'h00; psums[9] = 8'h00; psums[10] = 8'h00; psums[11] = 8'h00;
    psums[12] = 8'h33; psums[13] = 8'h20; psums[14] = 8'h01; psums[15] = 8'h32;
    run_pass(4, 4, 16'h0200, 100, 100, 1'b0, -1);
    chk("t2_words", 32'(log_n), 32'd1);
    chk("t2_data", log_data[0], 32'h33007F10);
    chk("t2_strb", 32'(log_strb[0]), 32'hF);
    chk("t2_addr", 32'(log_addr[0]), 32'h0200);
    chk("t2_en_count", 32'(en_count), 32'd16);
    chk("t2_init_count", 32'(init_count), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_init_pos", 32'(init_pos[i]), 32'(4 * i));
    chk("t2_relu_held", 32'(ppu_relu_sel), 32'd1);

    // K=1, 6 bytes: partial second word
    run_pass(1, 6, 16'h0300, 100, 100, 1'b1, -1);
    chk("t3_words", 32'(log_n), 32'd2);
    chk("t3_strb1", 32'(log_strb[1]), 32'b0011);
    chk("t3_upper1", log_data[1] >> 16, 32'd0);
    chk("t3_addr1", 32'(log_addr[1]), 32'h0304);

    // writeback stall of 5 cycles after the first word
    stall_after_first = 1'b1;
    run_pass(1, 8, 16'h0400, 100, 100, 1'b1, -1);
    stall_after_first = 1'b0;
    chk("t4_words", 32'(log_n), 32'd2);
    chk("t4_addr1", 32'(log_addr[1]), 32'h0404);

    // zero-length pass, then a start pulse injected mid-pass
    run_pass(3, 0, 16'h0700, 100, 100, 1'b0, -1);
    chk("t5_done_latency", 32'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), 32'd1);
    chk("t5_words", 32'(log_n), 32'd0);
    run_pass(2, 8, 16'h0800, 100, 100, 1'b1, 4);
    chk("t5b_words", 32'(log_n), 32'd2);
    chk("t5b_addr0", 32'(log_addr[0]), 32'h0800);

    // reset after three captured bytes, then a clean pass
    begin_pass(1, 12, 16'h0500, 100, 100, 1'b1);
    n = 0;
    while (m_idx < 3 && n < 100) begin step(); n++; end
    chk("t6_reached_3_bytes", 32'(m_idx >= 3), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("abort");
    repeat (5) step();
    chk("t6_no_wb_after_abort", 32'(log_n), 32'd0);
    run_pass(1, 5, 16'h0600, 100, 100, 1'b1, -1);
    chk("t6_words", 32'(log_n), 32'd2);
    chk("t6_addr0", 32'(log_addr[0]), 32'h0600);
    chk("t6_addr1", 32'(log_addr[1]), 32'h0604);
    chk("t6_strb1", 32'(log_strb[1]), 32'b0001);

    // address wrap at the top of the GLB space
    run_pass(2, 16, 16'hFFF8, 70, 70, 1'b1, -1);
    chk("wrap_addr2", 32'(log_addr[2]), 32'h0000);

    // randomized passes
    for (int p = 0; p < 24; p++) begin
      run_pass(int'($urandom_range(0, 7)), int'($urandom_range(0, 32)),
               int'({$urandom_range(0, 16'h3FFF), 2'b00}),
               int'($urandom_range(40, 100)), int'($urandom_range(40, 100)), 1'b1, -1);
      repeat (int'($urandom_range(0, 3))) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppu_wb_packer.md
Name: ppu_wb_packer

Overview:
- Consumer and sequencer on the output side of the PPU.
- Accepts psums by valid/ready handshake and drives the PPU controls: maxpool_en, maxpool_init, relu_sel.
- Captures each 8-bit PPU result and packs four results little-endian into 32-bit words.
- Issues the words as GLB writeback requests with byte strobes and incrementing addresses.

Parameters:
- ADDR_W, 16, width of GLB byte address.
- CNT_W, 16, width of output-byte counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle pulse; starts a pass when idle
- cfg_pool_size  in  3  psums per output byte K; 0 is treated as 1
- cfg_out_count  in  CNT_W  output bytes in the pass
- cfg_base_addr  in  ADDR_W  first word byte address (4-aligned)
- psum_valid  in  1  psum present on the PPU data_in path
- psum_ready  out  1  psum accepted this cycle when valid && ready
- ppu_maxpool_en  out  1  to PPU maxpool_en
- ppu_maxpool_init  out  1  to PPU maxpool_init
- ppu_relu_sel  out  1  to PPU relu_sel
- ppu_data_out  in  8  from PPU data_out
- wb_valid  out  1  write request valid
- wb_ready  in  1  GLB accepts the request
- wb_addr  out  ADDR_W  byte address of the word
- wb_data  out  32  packed word; lane i = bits 8i+7:8i
- wb_strb  out  4  byte enables
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset (synchronous, active-high): every output is 0, state is IDLE, all counters and pack/hold registers are cleared. Reset mid-pass discards partial data and issues no further wb requests.
- States:
  - IDLE: on cfg_start, latch cfg_* (0 → K=1). If out_count==0 go to DONE, else go to RUN.
  - RUN: accepts psums, packs bytes and issues words. When all out_count bytes are captured and the last word has been handed to hold, go to DRAIN.
  - DRAIN: wait for the hold word to be accepted (wb_valid && wb_ready), then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RUN and DRAIN. cfg_start is ignored outside IDLE.
- ppu_relu_sel = (K>1), registered at start; held until the next start.
- Psum acceptance:
  - psum_ready = RUN && !hold_valid && (psums issued < out_count*K).
  - Accepted psums outside RUN are impossible.
- PPU control for K>1:
  - ppu_maxpool_en = psum_valid && psum_ready.
  - ppu_maxpool_init = ppu_maxpool_en && win_cnt==0.
  - win_cnt counts 0..K-1 and wraps.
- PPU control for K=1: maxpool_en = maxpool_init = 0.
- Capture:
  - K=1: ppu_data_out is sampled in the same cycle the psum is accepted (PPU path is combinational).
  - K>1: sampled in the cycle after the K-th psum of a window is accepted (comparator registered). The next window's init psum may be accepted in that same cycle; there is no bubble.
- Packing:
  - The captured byte goes to lane byte_cnt[1:0].
  - On lane 3, or on the final byte of the pass, the pack register moves to hold next edge: hold_valid=1, wb_strb = filled lanes (e.g. 4'b0011 for 2 bytes), unfilled lanes 0.
  - The pack register is then cleared.
- Writeback:
  - wb_valid = hold_valid.
  - wb_addr/data/strb remain stable while wb_valid && !wb_ready.
  - The hold register clears on wb_valid && wb_ready.
  - wb_addr starts at cfg_base_addr and increments by 4 per accepted word; it wraps modulo 2^ADDR_W.
- Invariant (assert in the bench): a capture never coincides with a hold-to-pack collision. psum_ready=0 while hold is full, and for K≥2 captures are never back-to-back with a full hold.
- Latency: the last byte is captured, hold loads 1 cycle later, and wb_valid is asserted the same cycle. done follows the final wb handshake by 1 cycle.

Test Plan:
- K=1, out_count=8, base=0x0100, psums every cycle, PPU returns 0x01..0x08, wb_ready=1 → two words 0x04030201 @0x0100 and 0x08070605 @0x0104, strb 4'hF, maxpool_en never asserted, done once.
- K=4, out_count=4, window maxima 0x10,0x7F,0x00,0x33 → maxpool_init on psums 0,4,8,12, relu_sel=1, one word 0x33007F10 strb 4'hF.
- K=1, out_count=6 → second word strb 4'b0011, upper lanes 0, wb_addr base+4.
- wb_ready held 0 for 5 cycles after the first word → psum_ready=0 throughout, wb fields stable, no byte lost; the pass completes with the correct data.
- out_count=0 start → no psum_ready, no wb_valid, done pulse 1-2 cycles later. cfg_start during RUN is ignored.
- rst asserted mid-pass after 3 bytes → next cycle all outputs 0 and IDLE; a new pass starts cleanly at its own base address.
